// File: rtl/neuron_sequencer.sv
// neuron_sequencer: drives one shared multiply-accumulate datapath across
// every neuron of a fully-connected layer. For each neuron it loads the bias,
// accumulates one input*weight product per clock and applies a saturating
// ReLU. Each result is handed downstream over a valid/ready handshake.
module neuron_sequencer #(
    parameter int NUM_INPUTS  = 784,
    parameter int NUM_NEURONS = 16,
    parameter int FRAC_BITS   = 16,
    parameter int IN_AW       = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
    parameter int W_AW        = (NUM_INPUTS * NUM_NEURONS > 1) ? $clog2(NUM_INPUTS * NUM_NEURONS) : 1,
    parameter int N_AW        = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [IN_AW-1:0]  in_addr,
    input  logic [31:0]       in_data,
    output logic [W_AW-1:0]   w_addr,
    input  logic [31:0]       w_data,
    output logic [N_AW-1:0]   b_addr,
    input  logic [31:0]       b_data,
    output logic [31:0]       result,
    output logic [N_AW-1:0]   result_idx,
    output logic              result_valid,
    input  logic              result_ready
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        BIAS = 3'd1,
        MAC  = 3'd2,
        OUT  = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [IN_AW-1:0] I_LAST = IN_AW'(NUM_INPUTS - 1);
    localparam logic [IN_AW-1:0] I_ONE  = IN_AW'(1);
    localparam logic [N_AW-1:0]  N_LAST = N_AW'(NUM_NEURONS - 1);
    localparam logic [N_AW-1:0]  N_ONE  = N_AW'(1);

    state_t             state_r;
    logic [N_AW-1:0]    n_r;
    logic [IN_AW-1:0]   i_r;
    logic signed [47:0] acc_r;
    logic               busy_r;
    logic               done_r;
    logic [31:0]        result_r;
    logic [N_AW-1:0]    result_idx_r;
    logic               result_valid_r;

    logic signed [63:0] in_ext_s;
    logic signed [63:0] w_ext_s;
    logic signed [63:0] prod_full_s;
    logic signed [63:0] prod_shift_s;
    logic signed [47:0] prod_s;
    logic signed [47:0] acc_sum_s;

    // Negative sums clamp to zero; sums beyond the 32-bit positive range clamp to max.
    function automatic logic [31:0] relu_sat(input logic [47:0] a);
        logic [31:0] r;
        if (a[47]) begin
            r = 32'h0000_0000;
        end else if (|a[46:31]) begin
            r = 32'h7FFF_FFFF;
        end else begin
            r = a[31:0];
        end
        return r;
    endfunction

    // Fixed-point product of the current input and weight, realigned by FRAC_BITS.
    always_comb begin
        in_ext_s     = {{32{in_data[31]}}, in_data};
        w_ext_s      = {{32{w_data[31]}}, w_data};
        prod_full_s  = in_ext_s * w_ext_s;
        prod_shift_s = prod_full_s >>> FRAC_BITS;
        prod_s       = prod_shift_s[47:0];
        acc_sum_s    = acc_r + prod_s;
    end

    // Memory addresses follow the registered indices; zero outside their phase.
    always_comb begin
        in_addr = {IN_AW{1'b0}};
        w_addr  = {W_AW{1'b0}};
        b_addr  = {N_AW{1'b0}};
        case (state_r)
            BIAS: begin
                b_addr = n_r;
            end
            MAC: begin
                in_addr = i_r;
                w_addr  = W_AW'(n_r) * W_AW'(NUM_INPUTS) + W_AW'(i_r);
            end
            default: begin
                in_addr = {IN_AW{1'b0}};
            end
        endcase
    end

    // Sequencer FSM together with the accumulator and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            n_r            <= {N_AW{1'b0}};
            i_r            <= {IN_AW{1'b0}};
            acc_r          <= 48'sd0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            result_r       <= 32'h0000_0000;
            result_idx_r   <= {N_AW{1'b0}};
            result_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r <= BIAS;
                        busy_r  <= 1'b1;
                        n_r     <= {N_AW{1'b0}};
                        i_r     <= {IN_AW{1'b0}};
                    end
                end
                BIAS: begin
                    acc_r   <= {{16{b_data[31]}}, b_data};
                    i_r     <= {IN_AW{1'b0}};
                    state_r <= MAC;
                end
                MAC: begin
                    acc_r <= acc_sum_s;
                    if (i_r == I_LAST) begin
                        result_r       <= relu_sat(acc_sum_s);
                        result_idx_r   <= n_r;
                        result_valid_r <= 1'b1;
                        state_r        <= OUT;
                    end else begin
                        i_r <= i_r + I_ONE;
                    end
                end
                OUT: begin
                    // Result is held until the downstream stage takes it.
                    if (result_ready && result_valid_r) begin
                        result_valid_r <= 1'b0;
                        if (n_r == N_LAST) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else begin
                            n_r     <= n_r + N_ONE;
                            state_r <= BIAS;
                        end
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    n_r     <= {N_AW{1'b0}};
                    i_r     <= {IN_AW{1'b0}};
                    state_r <= IDLE;
                end
                default: begin
                    state_r        <= IDLE;
                    busy_r         <= 1'b0;
                    done_r         <= 1'b0;
                    result_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = busy_r;
    assign done         = done_r;
    assign result       = result_r;
    assign result_idx   = result_idx_r;
    assign result_valid = result_valid_r;

endmodule

// File: tb/tb_neuron_sequencer.sv
// Directed bench for neuron_sequencer using three small configurations:
//   a: 2 inputs x 1 neuron, b: 4 inputs x 1 neuron, c: 3 inputs x 2 neurons.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_neuron_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // ---------------- instance a: 2 inputs, 1 neuron ----------------
    logic        start_a, busy_a, done_a, rv_a, ready_a;
    logic [0:0]  in_addr_a, w_addr_a, b_addr_a, idx_a;
    logic [31:0] in_data_a, w_data_a, b_data_a, result_a;
    logic [31:0] in_mem_a [0:1];
    logic [31:0] w_mem_a  [0:1];
    logic [31:0] b_mem_a  [0:1];
    assign in_data_a = in_mem_a[in_addr_a];
    assign w_data_a  = w_mem_a[w_addr_a];
    assign b_data_a  = b_mem_a[b_addr_a];

    neuron_sequencer #(.NUM_INPUTS(2), .NUM_NEURONS(1), .FRAC_BITS(16)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
        .in_addr(in_addr_a), .in_data(in_data_a), .w_addr(w_addr_a), .w_data(w_data_a),
        .b_addr(b_addr_a), .b_data(b_data_a), .result(result_a), .result_idx(idx_a),
        .result_valid(rv_a), .result_ready(ready_a)
    );

    // ---------------- instance b: 4 inputs, 1 neuron ----------------
    logic        start_b, busy_b, done_b, rv_b, ready_b;
    logic [1:0]  in_addr_b, w_addr_b;
    logic [0:0]  b_addr_b, idx_b;
    logic [31:0] in_data_b, w_data_b, b_data_b, result_b;
    logic [31:0] in_mem_b [0:3];
    logic [31:0] w_mem_b  [0:3];
    logic [31:0] b_mem_b  [0:1];
    assign in_data_b = in_mem_b[in_addr_b];
    assign w_data_b  = w_mem_b[w_addr_b];
    assign b_data_b  = b_mem_b[b_addr_b];

    neuron_sequencer #(.NUM_INPUTS(4), .NUM_NEURONS(1), .FRAC_BITS(16)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
        .in_addr(in_addr_b), .in_data(in_data_b), .w_addr(w_addr_b), .w_data(w_data_b),
        .b_addr(b_addr_b), .b_data(b_data_b), .result(result_b), .result_idx(idx_b),
        .result_valid(rv_b), .result_ready(ready_b)
    );

    // ---------------- instance c: 3 inputs, 2 neurons ----------------
    logic        start_c, busy_c, done_c, rv_c, ready_c;
    logic [1:0]  in_addr_c;
    logic [2:0]  w_addr_c;
    logic [0:0]  b_addr_c, idx_c;
    logic [31:0] in_data_c, w_data_c, b_data_c, result_c;
    logic [31:0] in_mem_c [0:3];
    logic [31:0] w_mem_c  [0:7];
    logic [31:0] b_mem_c  [0:1];
    assign in_data_c = in_mem_c[in_addr_c];
    assign w_data_c  = w_mem_c[w_addr_c];
    assign b_data_c  = b_mem_c[b_addr_c];

    neuron_sequencer #(.NUM_INPUTS(3), .NUM_NEURONS(2), .FRAC_BITS(16)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .busy(busy_c), .done(done_c),
        .in_addr(in_addr_c), .in_data(in_data_c), .w_addr(w_addr_c), .w_data(w_data_c),
        .b_addr(b_addr_c), .b_data(b_data_c), .result(result_c), .result_idx(idx_c),
        .result_valid(rv_c), .result_ready(ready_c)
    );

    // Hand-computed results for instance c:
    // neuron 0: 1*1 + 2*1 + 3*1 + 0.5      = 6.5 -> 0x00068000
    // neuron 1: 1*2 + 2*(-1) + 3*1 + (-1)  = 2.0 -> 0x00020000
    localparam logic [31:0] C_RES0 = 32'h0006_8000;
    localparam logic [31:0] C_RES1 = 32'h0002_0000;

    task automatic test_reset();
        checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || rv_a !== 1'b0 || result_a !== 32'h0 || idx_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_a busy=%b done=%b rv=%b result=%h idx=%b required all zero", busy_a, done_a, rv_a, result_a, idx_a);
        end
        checks++;
        if (in_addr_c !== 2'd0 || w_addr_c !== 3'd0 || b_addr_c !== 1'b0 || busy_c !== 1'b0 || rv_c !== 1'b0) begin
            errors++;
            $display("FAIL reset_c in_addr=%0d w_addr=%0d b_addr=%0d busy=%b rv=%b required all zero", in_addr_c, w_addr_c, b_addr_c, busy_c, rv_c);
        end
    endtask

    task automatic test_basic();
        in_mem_a[0] = 32'h0002_0000; in_mem_a[1] = 32'h0003_0000;
        w_mem_a[0]  = 32'h0000_8000; w_mem_a[1]  = 32'h0001_0000;
        b_mem_a[0]  = 32'h0001_0000; b_mem_a[1]  = 32'h0;
        ready_a = 1'b1;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;      // edge 0 sampled start
        @(negedge clk);                      // after edge 1
        @(negedge clk);                      // after edge 2
        checks++;
        if (rv_a !== 1'b0) begin
            errors++;
            $display("FAIL basic_early_valid rv=%b required 0 after edge 2", rv_a);
        end
        @(negedge clk);                      // after edge 3
        checks++;
        if (rv_a !== 1'b1 || result_a !== 32'h0005_0000 || idx_a !== 1'b0) begin
            errors++;
            $display("FAIL basic_result rv=%b result=%h idx=%b required 1 00050000 0", rv_a, result_a, idx_a);
        end
        @(negedge clk);                      // after edge 4: accepted -> DONE
        checks++;
        if (done_a !== 1'b1 || rv_a !== 1'b0 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL basic_done done=%b rv=%b busy=%b required 1 0 1", done_a, rv_a, busy_a);
        end
        @(negedge clk);
        checks++;
        if (done_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle done=%b busy=%b required 0 0", done_a, busy_a);
        end
    endtask

    task automatic test_relu();
        in_mem_a[0] = 32'h0; in_mem_a[1] = 32'h0;
        b_mem_a[0]  = 32'hFFF0_0000;          // -16.0
        ready_a = 1'b1;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (rv_a !== 1'b1 || result_a !== 32'h0) begin
            errors++;
            $display("FAIL relu_negative rv=%b result=%h required 1 00000000", rv_a, result_a);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_saturation();
        // max * 1.0 four times: 4*(2^31-1) overflows the 32-bit range -> clamp.
        for (int k = 0; k < 4; k++) begin
            in_mem_b[k] = 32'h7FFF_FFFF;
            w_mem_b[k]  = 32'h0001_0000;
        end
        b_mem_b[0] = 32'h0; b_mem_b[1] = 32'h0;
        ready_b = 1'b1;
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (rv_b !== 1'b1 || result_b !== 32'h7FFF_FFFF) begin
            errors++;
            $display("FAIL sat_positive rv=%b result=%h required 1 7fffffff", rv_b, result_b);
        end
        repeat (2) @(negedge clk);
        // max * max: each product is 0x3FFFFFFF0000; four of them wrap the
        // 48-bit accumulator to 0xFFFFFFFC0000 (negative) -> ReLU gives 0.
        for (int k = 0; k < 4; k++) w_mem_b[k] = 32'h7FFF_FFFF;
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (rv_b !== 1'b1 || result_b !== 32'h0) begin
            errors++;
            $display("FAIL sat_wrap rv=%b result=%h required 1 00000000", rv_b, result_b);
        end
        repeat (2) @(negedge clk);
    endtask

    // Full pass on instance c with ready held high; optionally pulses start mid-MAC.
    task automatic c_pass(input bit mid_start);
        int dones = 0;
        int nn;
        int ii;
        ready_c = 1'b1;
        @(negedge clk) start_c = 1'b1;
        @(negedge clk) start_c = 1'b0;       // edge 0 sampled start, now BIAS n=0
        checks++;
        if (b_addr_c !== 1'b0 || busy_c !== 1'b1) begin
            errors++;
            $display("FAIL multi_bias0 b_addr=%0d busy=%b required 0 1", b_addr_c, busy_c);
        end
        for (int k = 1; k <= 11; k++) begin
            start_c = (mid_start && k == 2) ? 1'b1 : 1'b0;
            @(negedge clk);
            if (done_c === 1'b1) dones++;
            case (k)
                1, 2, 3, 6, 7, 8: begin
                    nn = (k > 5) ? 1 : 0;
                    ii = (k > 5) ? k - 6 : k - 1;
                    checks++;
                    if (int'(w_addr_c) !== nn * 3 + ii || int'(in_addr_c) !== ii || rv_c !== 1'b0) begin
                        errors++;
                        $display("FAIL multi_addr k=%0d w_addr=%0d in_addr=%0d rv=%b required %0d %0d 0", k, w_addr_c, in_addr_c, rv_c, nn * 3 + ii, ii);
                    end
                end
                4: begin
                    checks++;
                    if (rv_c !== 1'b1 || idx_c !== 1'b0 || result_c !== C_RES0) begin
                        errors++;
                        $display("FAIL multi_res0 rv=%b idx=%b result=%h required 1 0 %h", rv_c, idx_c, result_c, C_RES0);
                    end
                end
                5: begin
                    checks++;
                    if (b_addr_c !== 1'b1 || rv_c !== 1'b0) begin
                        errors++;
                        $display("FAIL multi_bias1 b_addr=%0d rv=%b required 1 0", b_addr_c, rv_c);
                    end
                end
                9: begin
                    checks++;
                    if (rv_c !== 1'b1 || idx_c !== 1'b1 || result_c !== C_RES1) begin
                        errors++;
                        $display("FAIL multi_res1 rv=%b idx=%b result=%h required 1 1 %h", rv_c, idx_c, result_c, C_RES1);
                    end
                end
                10: begin
                    // 11th cycle counting the cycle in which start was sampled
                    checks++;
                    if (done_c !== 1'b1) begin
                        errors++;
                        $display("FAIL multi_done_time done=%b required 1 after edge 10", done_c);
                    end
                end
                11: begin
                    checks++;
                    if (done_c !== 1'b0 || busy_c !== 1'b0) begin
                        errors++;
                        $display("FAIL multi_idle done=%b busy=%b required 0 0", done_c, busy_c);
                    end
                end
                default: begin
                end
            endcase
        end
        checks++;
        if (dones !== 1) begin
            errors++;
            $display("FAIL multi_done_count got %0d required 1", dones);
        end
    endtask

    task automatic test_multi();
        c_pass(1'b0);
    endtask

    task automatic test_start_during_mac();
        c_pass(1'b1);
    endtask

    task automatic test_backpressure();
        ready_c = 1'b0;
        @(negedge clk) start_c = 1'b1;
        @(negedge clk) start_c = 1'b0;
        repeat (4) @(negedge clk);           // after edge 4: OUT, neuron 0
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (rv_c !== 1'b1 || result_c !== C_RES0 || idx_c !== 1'b0 || busy_c !== 1'b1 ||
                w_addr_c !== 3'd0 || in_addr_c !== 2'd0 || b_addr_c !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold k=%0d rv=%b result=%h idx=%b busy=%b w=%0d in=%0d b=%0d", k, rv_c, result_c, idx_c, busy_c, w_addr_c, in_addr_c, b_addr_c);
            end
            @(negedge clk);
        end
        ready_c = 1'b1;
        @(negedge clk);                      // accepting edge -> BIAS neuron 1
        ready_c = 1'b0;
        checks++;
        if (rv_c !== 1'b0 || b_addr_c !== 1'b1 || busy_c !== 1'b1) begin
            errors++;
            $display("FAIL bp_next_bias rv=%b b_addr=%0d busy=%b required 0 1 1", rv_c, b_addr_c, busy_c);
        end
        repeat (4) @(negedge clk);           // BIAS + 3 MAC -> OUT neuron 1
        checks++;
        if (rv_c !== 1'b1 || result_c !== C_RES1 || idx_c !== 1'b1) begin
            errors++;
            $display("FAIL bp_res1 rv=%b result=%h idx=%b required 1 %h 1", rv_c, result_c, idx_c, C_RES1);
        end
        @(negedge clk);
        checks++;
        if (done_c !== 1'b0 || rv_c !== 1'b1) begin
            errors++;
            $display("FAIL bp_no_early_done done=%b rv=%b required 0 1", done_c, rv_c);
        end
        ready_c = 1'b1;
        @(negedge clk);
        checks++;
        if (done_c !== 1'b1) begin
            errors++;
            $display("FAIL bp_done done=%b required 1", done_c);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_pass();
        ready_c = 1'b1;
        @(negedge clk) start_c = 1'b1;
        @(negedge clk) start_c = 1'b0;
        repeat (6) @(negedge clk);           // after edge 6: MAC of neuron 1
        checks++;
        if (result_c !== C_RES0 || busy_c !== 1'b1 || w_addr_c !== 3'd3) begin
            errors++;
            $display("FAIL rst_pre result=%h busy=%b w_addr=%0d required %h 1 3", result_c, busy_c, w_addr_c, C_RES0);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy_c !== 1'b0 || done_c !== 1'b0 || rv_c !== 1'b0 || result_c !== 32'h0 || idx_c !== 1'b0 ||
            w_addr_c !== 3'd0 || in_addr_c !== 2'd0 || b_addr_c !== 1'b0) begin
            errors++;
            $display("FAIL rst_async busy=%b done=%b rv=%b result=%h idx=%b w=%0d in=%0d b=%0d required all zero", busy_c, done_c, rv_c, result_c, idx_c, w_addr_c, in_addr_c, b_addr_c);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (done_c !== 1'b0) begin
                errors++;
                $display("FAIL rst_no_done done=%b required 0", done_c);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        c_pass(1'b0);
    endtask

    initial begin
        rst_n   = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        ready_a = 1'b0; ready_b = 1'b0; ready_c = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_mem_a[k] = 32'h0; w_mem_a[k] = 32'h0; b_mem_a[k] = 32'h0;
            b_mem_b[k]  = 32'h0;
        end
        for (int k = 0; k < 4; k++) begin
            in_mem_b[k] = 32'h0; w_mem_b[k] = 32'h0; in_mem_c[k] = 32'h0;
        end
        in_mem_c[0] = 32'h0001_0000; in_mem_c[1] = 32'h0002_0000; in_mem_c[2] = 32'h0003_0000;
        w_mem_c[0]  = 32'h0001_0000; w_mem_c[1]  = 32'h0001_0000; w_mem_c[2]  = 32'h0001_0000;
        w_mem_c[3]  = 32'h0002_0000; w_mem_c[4]  = 32'hFFFF_0000; w_mem_c[5]  = 32'h0001_0000;
        w_mem_c[6]  = 32'h0;         w_mem_c[7]  = 32'h0;
        b_mem_c[0]  = 32'h0000_8000; b_mem_c[1]  = 32'hFFFF_0000;

        @(negedge clk);
        test_reset();
        @(negedge clk) rst_n = 1'b1;

        test_basic();
        test_relu();
        test_saturation();
        test_multi();
        test_backpressure();
        test_start_during_mac();
        test_reset_mid_pass();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
